seq_bin2bcd_display: RTL and testbench
======================================

Name: seq_bin2bcd_display

Overview:
- Downstream result-display stage for the multiplier/square-root unit.
- Captures the signed two's-complement result when the unit pulses ready, then converts the magnitude to packed BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock.
- Drives registered BCD digits, a sign flag and active-low seven-segment codes for the board displays.
- Displayed values hold steady until a new conversion completes.

Parameters:
- WORD_LENGTH, 16: width of signed input word.
- DIGITS, 5: number of BCD digits. Must satisfy 10^DIGITS > 2^(WORD_LENGTH-1).
- BLANK, 1: 1 blanks leading-zero digits (units digit never blanked); 0 shows all digits.

Ports:
- clk  in  1  system clock (5 MHz domain).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  start conversion. Level sampled, acted on only in IDLE.
- bin  in  WORD_LENGTH  signed two's-complement value, sampled on accepted enable.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; new outputs valid.
- bcd  out  4*DIGITS  packed BCD magnitude, digit 0 = units in bits [3:0].
- sign  out  1  1 = displayed value negative.
- seg  out  7*DIGITS  active-low gfedcba code per digit, digit 0 in bits [6:0].

Behaviour:
- Reset and clock:
  - One clock; all state changes on rising clk.
  - reset has priority over everything, is synchronous, and aborts any conversion mid-operation.
- Reset values:
  - State: IDLE.
  - busy=0, done=0, bcd=0, sign=0.
  - seg: units digit shows "0" (1000000); other digits blank (1111111) if BLANK=1, else "0".
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If enable=1 at edge E0, latch sign=bin[MSB] internally and mag=|bin| as a WORD_LENGTH-bit unsigned value (-2^(WORD_LENGTH-1) maps to 2^(WORD_LENGTH-1), no overflow).
  - Clear the scratch BCD register, load the bit counter with WORD_LENGTH, go to SHIFT, busy=1.
- SHIFT, one iteration per cycle:
  - Every scratch nibble >=5 gets +3.
  - Then shift {scratch, mag} left by 1.
  - Decrement the counter.
  - After WORD_LENGTH iterations (edges E1..E_WL) go to DONE.
- DONE (edge E_WL+1):
  - Transfer scratch to bcd and the latched sign to sign.
  - Compute seg from the new bcd.
  - done=1 and busy=0 for this single cycle.
  - Return to IDLE.
- Latency: done is high in the cycle after edge E0+WORD_LENGTH+1, i.e. 17 clocks after enable for the default.
- enable while busy=1: ignored, no queuing.
- enable in the done cycle: accepted (state is IDLE then), giving back-to-back conversions at 18-cycle spacing.
- bcd, sign and seg change only at the DONE edge or on reset; no intermediate values are ever visible.
- Zero result: sign=0 always.
- Seven-segment codes (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Blanking (BLANK=1): digit k>0 is blank iff it and all higher digits are zero.
- Nibbles are guaranteed 0-9 by construction; any other value maps to blank.

Test Plan:
- Reset, then bin=16'h3039 (12345), enable for 1 cycle -> busy for cycles 1-16; done pulse at cycle 17; bcd=20'h12345, sign=0, all five digits lit.
- bin=16'hFFFF (-1) -> bcd=20'h00001, sign=1, seg digit 0=1111001, digits 1-4=1111111.
- bin=16'h8000 (-32768) -> bcd=20'h32768, sign=1. bin=16'h7FFF -> bcd=20'h32767, sign=0.
- bin=0 -> bcd=0, sign=0, units "0" and rest blank. Repeat with BLANK=0 -> all digits 1000000.
- Second enable with bin=5 at cycle 8 of a conversion of 100 -> ignored; result 100 with a single done pulse. Then enable held high continuously -> conversions every 18 cycles.
- reset asserted at cycle 10 of a conversion of 999 -> next cycle busy=0 and outputs at reset values. A fresh conversion of 42 then completes normally with bcd=20'h00042.

Source files
------------

// File: rtl/seq_bin2bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : seq_bin2bcd_display
// Brief    : Signed result capture, iterative double-dabble binary-to-BCD
//            conversion and registered active-low seven-segment drive.
// Revision : 1.0  initial release
// ============================================================================
module seq_bin2bcd_display #(
   parameter int WORD_LENGTH = 16,
   parameter int DIGITS      = 5,
   parameter bit BLANK       = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [WORD_LENGTH-1:0]   bin,
   output logic                     busy,
   output logic                     done,
   output logic [4*DIGITS-1:0]      bcd,
   output logic                     sign,
   output logic [7*DIGITS-1:0]      seg
);

   localparam int c_bcd_w = 4 * DIGITS;
   localparam int c_seg_w = 7 * DIGITS;
   localparam int c_cnt_w = $clog2(WORD_LENGTH + 1);

   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WORD_LENGTH);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [6:0]         c_seg_zero  = 7'b1000000;
   localparam logic [6:0]         c_seg_blank = 7'b1111111;

   function automatic logic [c_seg_w-1:0] seg_reset_code();
      logic [c_seg_w-1:0] v;
      v = '1;
      for (int k = 0; k < DIGITS; k++)
         v[7*k +: 7] = (k == 0 || !BLANK) ? c_seg_zero : c_seg_blank;
      return v;
   endfunction

   localparam logic [c_seg_w-1:0] c_seg_reset = seg_reset_code();

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = c_seg_blank;
      endcase
      return s;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [WORD_LENGTH-1:0]         r_mag;
   logic [c_bcd_w-1:0]             r_scratch;
   logic [c_cnt_w-1:0]             r_cnt;
   logic                           r_sign_lat;
   logic                           r_busy;
   logic                           r_done;
   logic [c_bcd_w-1:0]             r_bcd;
   logic                           r_sign;
   logic [c_seg_w-1:0]             r_seg;

   logic                           w_accept;
   logic                           w_shift;
   logic                           w_finish;
   logic [WORD_LENGTH-1:0]         w_abs;
   logic [c_bcd_w-1:0]             w_adj;
   logic [c_bcd_w+WORD_LENGTH-1:0] w_shifted;
   logic [c_seg_w-1:0]             w_seg_next;

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_shift      = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_accept     = 1'b1;
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_shift = 1'b1;
            if (r_cnt == c_cnt_one)
               w_state_next = ST_DONE;
         end
         ST_DONE: begin
            w_finish     = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Most negative input negates to itself, which is the correct unsigned magnitude.
   assign w_abs = bin[WORD_LENGTH-1] ? (~bin + {{(WORD_LENGTH-1){1'b0}}, 1'b1}) : bin;

   assign w_shifted = {w_adj, r_mag} << 1;

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      assign w_adj[4*k +: 4] = (r_scratch[4*k +: 4] >= 4'd5) ?
                               (r_scratch[4*k +: 4] + 4'd3) : r_scratch[4*k +: 4];
      if (k == 0) begin : g_units
         assign w_seg_next[6:0] = seg_decode(r_scratch[3:0]);
      end else begin : g_upper
         // Blank only when this digit and every digit above it are zero.
         logic w_blank;
         assign w_blank = BLANK && (r_scratch[c_bcd_w-1:4*k] == '0);
         assign w_seg_next[7*k +: 7] = w_blank ? c_seg_blank : seg_decode(r_scratch[4*k +: 4]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mag      <= '0;
         r_scratch  <= '0;
         r_cnt      <= '0;
         r_sign_lat <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_bcd      <= '0;
         r_sign     <= 1'b0;
         r_seg      <= c_seg_reset;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_sign_lat <= bin[WORD_LENGTH-1];
            r_mag      <= w_abs;
            r_scratch  <= '0;
            r_cnt      <= c_cnt_load;
            r_busy     <= 1'b1;
         end
         if (w_shift) begin
            r_scratch <= w_shifted[c_bcd_w+WORD_LENGTH-1:WORD_LENGTH];
            r_mag     <= w_shifted[WORD_LENGTH-1:0];
            r_cnt     <= r_cnt - c_cnt_one;
         end
         if (w_finish) begin
            r_bcd  <= r_scratch;
            r_sign <= r_sign_lat;
            r_seg  <= w_seg_next;
            r_done <= 1'b1;
            r_busy <= 1'b0;
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign bcd  = r_bcd;
   assign sign = r_sign;
   assign seg  = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seq_bin2bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_bin2bcd_display
// Brief    : Self-checking bench: directed vector table, random values against
//            an arithmetic reference model, and multi-cycle corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_bin2bcd_display;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                          S9 = 7'b0010000, SB = 7'b1111111;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] bin;
   logic        busy, done, sign;
   logic [19:0] bcd;
   logic [34:0] seg;
   logic        busy_nb, done_nb, sign_nb;
   logic [19:0] bcd_nb;
   logic [34:0] seg_nb;

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] seg_tab [10] = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};

   seq_bin2bcd_display #(.WORD_LENGTH(16), .DIGITS(5), .BLANK(1'b1)) dut (
      .clk(clk), .reset(reset), .enable(enable), .bin(bin),
      .busy(busy), .done(done), .bcd(bcd), .sign(sign), .seg(seg));

   seq_bin2bcd_display #(.WORD_LENGTH(16), .DIGITS(5), .BLANK(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .enable(enable), .bin(bin),
      .busy(busy_nb), .done(done_nb), .bcd(bcd_nb), .sign(sign_nb), .seg(seg_nb));

   always #100 clk = ~clk;

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: decimal digits from plain integer arithmetic.
   function automatic void model(input logic [15:0] b, input bit blank,
                                 output logic [19:0] e_bcd, output logic e_sign,
                                 output logic [34:0] e_seg);
      int v, m, p, d;
      v = int'(signed'(b));
      m = (v < 0) ? -v : v;
      e_sign = (v < 0);
      p = 1;
      for (int k = 0; k < 5; k++) begin
         d = (m / p) % 10;
         e_bcd[4*k +: 4] = 4'(d);
         e_seg[7*k +: 7] = (blank && k > 0 && m < p) ? SB : seg_tab[d];
         p = p * 10;
      end
   endfunction

   task automatic convert(input logic [15:0] v, input string tag);
      int k;
      bit seen, stable;
      logic [19:0] prev;
      prev   = bcd;
      stable = 1'b1;
      seen   = 1'b0;
      @(negedge clk);
      bin    = v;
      enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      check({tag, "_busy_start"}, 64'(busy), 64'd1);
      k = 0;
      while (!seen && k < 40) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (bcd !== prev || busy !== 1'b1) stable = 1'b0;
      end
      check({tag, "_latency"}, 64'(k), 64'd17);
      check({tag, "_hold_while_busy"}, 64'(stable), 64'd1);
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done_single"}, 64'(done), 64'd0);
   endtask

   typedef struct {
      logic [15:0] bin;
      logic [19:0] bcd;
      logic        sign;
      logic [34:0] seg;
      logic [34:0] seg_nb;
   } vec_t;

   vec_t vecs [6];

   initial begin : main
      logic [19:0] e_bcd;
      logic        e_sign;
      logic [34:0] e_seg, e_seg_nb;
      logic [15:0] r;
      int          cnt, d1, d2;

      vecs[0] = '{16'h3039, 20'h12345, 1'b0, {S1, S2, S3, S4, S5}, {S1, S2, S3, S4, S5}};
      vecs[1] = '{16'hFFFF, 20'h00001, 1'b1, {SB, SB, SB, SB, S1}, {S0, S0, S0, S0, S1}};
      vecs[2] = '{16'h8000, 20'h32768, 1'b1, {S3, S2, S7, S6, S8}, {S3, S2, S7, S6, S8}};
      vecs[3] = '{16'h7FFF, 20'h32767, 1'b0, {S3, S2, S7, S6, S7}, {S3, S2, S7, S6, S7}};
      vecs[4] = '{16'h0000, 20'h00000, 1'b0, {SB, SB, SB, SB, S0}, {S0, S0, S0, S0, S0}};
      vecs[5] = '{16'hFC18, 20'h01000, 1'b1, {SB, S1, S0, S0, S0}, {S0, S1, S0, S0, S0}};

      reset  = 1'b1;
      enable = 1'b0;
      bin    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_bcd", 64'(bcd), 64'd0);
      check("rst_sign", 64'(sign), 64'd0);
      check("rst_seg", 64'(seg), 64'({SB, SB, SB, SB, S0}));
      check("rst_seg_noblank", 64'(seg_nb), 64'({S0, S0, S0, S0, S0}));
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         convert(vecs[i].bin, $sformatf("vec%0d", i));
         check($sformatf("vec%0d_bcd", i), 64'(bcd), 64'(vecs[i].bcd));
         check($sformatf("vec%0d_sign", i), 64'(sign), 64'(vecs[i].sign));
         check($sformatf("vec%0d_seg", i), 64'(seg), 64'(vecs[i].seg));
         check($sformatf("vec%0d_seg_noblank", i), 64'(seg_nb), 64'(vecs[i].seg_nb));
      end

      for (int i = 0; i < 25; i++) begin
         r = 16'($urandom);
         if (i % 5 == 1) r = 16'($urandom_range(0, 120));
         if (i % 5 == 2) r = 16'(-int'($urandom_range(0, 120)));
         convert(r, $sformatf("rnd%0d", i));
         model(r, 1'b1, e_bcd, e_sign, e_seg);
         model(r, 1'b0, e_bcd, e_sign, e_seg_nb);
         check($sformatf("rnd%0d_bcd_%0h", i, r), 64'(bcd), 64'(e_bcd));
         check($sformatf("rnd%0d_sign_%0h", i, r), 64'(sign), 64'(e_sign));
         check($sformatf("rnd%0d_seg_%0h", i, r), 64'(seg), 64'(e_seg));
         check($sformatf("rnd%0d_seg_noblank_%0h", i, r), 64'(seg_nb), 64'(e_seg_nb));
      end

      // Second enable mid-conversion must be dropped.
      @(negedge clk);
      bin = 16'd100; enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      bin = 16'd5; enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) cnt++;
      end
      check("ignore_busy_done_count", 64'(cnt), 64'd1);
      check("ignore_busy_bcd", 64'(bcd), 64'h00100);

      // Enable held high: back-to-back conversions.
      @(negedge clk);
      bin = 16'hFCF7; enable = 1'b1;
      cnt = 0; d1 = 0; d2 = 0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            cnt++;
            if (cnt == 1) d1 = c;
            if (cnt == 2) d2 = c;
         end
      end
      enable = 1'b0;
      check("b2b_first_done", 64'(d1), 64'd18);
      check("b2b_spacing", 64'(d2 - d1), 64'd18);
      check("b2b_count", 64'(cnt), 64'd3);
      check("b2b_bcd", 64'(bcd), 64'h00777);
      check("b2b_sign", 64'(sign), 64'd1);
      repeat (25) @(posedge clk);

      // Reset aborts a conversion in progress.
      @(negedge clk);
      bin = 16'd999; enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_bcd", 64'(bcd), 64'd0);
      check("abort_sign", 64'(sign), 64'd0);
      check("abort_seg", 64'(seg), 64'({SB, SB, SB, SB, S0}));
      check("abort_seg_noblank", 64'(seg_nb), 64'({S0, S0, S0, S0, S0}));
      cnt = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done || busy) cnt++;
      end
      check("abort_no_activity", 64'(cnt), 64'd0);
      convert(16'd42, "after_abort");
      check("after_abort_bcd", 64'(bcd), 64'h00042);
      check("after_abort_sign", 64'(sign), 64'd0);
      check("after_abort_seg", 64'(seg), 64'({SB, SB, SB, S4, S2}));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
